// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, the decoded-bundle struct and the DATA_W legality check.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [4:0] REG_RA   = 5'd31;

  // Decoded instruction minus the width-parameterized immediate.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic [25:0] jtarget;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        illegal;
  } dec_t;

  function automatic bit data_w_ok(int w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction, immediate extension and control generation.
module instr_field_decode
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instruction,
  output dec_t              dec,
  output logic [DATA_W-1:0] imm,
  output logic              reads_rt
);

  logic [5:0] op;
  assign op = instruction[31:26];

  // Fields, destination select and control flags.
  always_comb begin
    dec         = '0;
    dec.opcode  = op;
    dec.funct   = instruction[5:0];
    dec.rs      = instruction[25:21];
    dec.rt      = instruction[20:16];
    dec.rd      = instruction[15:11];
    dec.shamt   = instruction[10:6];
    dec.jtarget = instruction[25:0];
    dec.dest    = instruction[20:16];
    case (op)
      OP_RTYPE: begin
        dec.dest      = instruction[15:11];
        dec.reg_write = (instruction[5:0] != FN_JR);
      end
      OP_JAL: begin
        dec.dest      = REG_RA;
        dec.reg_write = 1'b1;
      end
      OP_J, OP_BEQ, OP_BNE: ;
      OP_ADDI, 6'h09, 6'h0A, 6'h0B, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        dec.reg_write = 1'b1;
      OP_LW: begin
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_SW: dec.mem_write = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
    // Writes to $zero are architecturally dropped.
    if (dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

  // Immediate: zero-extend logical ops, LUI shifts up then sign-extends, rest sign-extend.
  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm = DATA_W'(instruction[15:0]);
      OP_LUI:                   imm = DATA_W'($signed({instruction[15:0], 16'h0000}));
      default:                  imm = DATA_W'($signed(instruction[15:0]));
    endcase
  end

  // Opcodes whose rt is a source operand (matters for load-use detection).
  always_comb begin
    reads_rt = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  end

endmodule

// File: rtl/id_stage_decoder.sv
// ID stage: valid/ready handshake, load-use bubble insertion, flush and the output register.
module id_stage_decoder
  import mips_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instruction,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [ADDR_W-1:0] o_pc,
  output logic [5:0]        o_opcode,
  output logic [5:0]        o_funct,
  output logic [4:0]        o_rs,
  output logic [4:0]        o_rt,
  output logic [4:0]        o_rd,
  output logic [4:0]        o_shamt,
  output logic [4:0]        o_dest,
  output logic [DATA_W-1:0] o_imm,
  output logic [25:0]       o_jtarget,
  output logic              o_reg_write,
  output logic              o_mem_read,
  output logic              o_mem_write,
  output logic              o_illegal,
  output logic [15:0]       o_stall_count
);

  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("id_stage_decoder: DATA_W must be 32 or 64");
  end

  dec_t              dec_in, dec_q;
  logic [DATA_W-1:0] imm_in, imm_q;
  logic [ADDR_W-1:0] pc_q;
  logic              reads_rt, vld_q, hazard, in_xfer;
  logic [15:0]       stall_q;

  instr_field_decode #(.DATA_W(DATA_W)) u_dec (
    .instruction (i_instruction),
    .dec         (dec_in),
    .imm         (imm_in),
    .reads_rt    (reads_rt)
  );

  // Held LW whose destination is a source of the incoming instruction.
  assign hazard = LOAD_USE_EN && vld_q && dec_q.mem_read && (dec_q.dest != 5'd0) && i_valid &&
                  ((dec_in.rs == dec_q.dest) || ((dec_in.rt == dec_q.dest) && reads_rt));

  // Flush always drains; otherwise accept when the output slot frees and no hazard.
  assign o_ready = !i_reset && (i_flush || ((!vld_q || i_ready) && !hazard));
  assign in_xfer = i_valid && o_ready && !i_flush;

  // Output register: flush > load > drain (a drain under hazard is a counted bubble).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_q   <= 1'b0;
      dec_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      stall_q <= '0;
    end else if (i_flush) begin
      vld_q <= 1'b0;
    end else if (in_xfer) begin
      vld_q <= 1'b1;
      dec_q <= dec_in;
      imm_q <= imm_in;
      pc_q  <= i_pc;
    end else if (vld_q && i_ready) begin
      vld_q <= 1'b0;
      if (hazard && (stall_q != 16'hFFFF)) stall_q <= stall_q + 16'd1;
    end
  end

  assign o_valid       = vld_q;
  assign o_pc          = pc_q;
  assign o_opcode      = dec_q.opcode;
  assign o_funct       = dec_q.funct;
  assign o_rs          = dec_q.rs;
  assign o_rt          = dec_q.rt;
  assign o_rd          = dec_q.rd;
  assign o_shamt       = dec_q.shamt;
  assign o_dest        = dec_q.dest;
  assign o_imm         = imm_q;
  assign o_jtarget     = dec_q.jtarget;
  assign o_reg_write   = vld_q && dec_q.reg_write;
  assign o_mem_read    = vld_q && dec_q.mem_read;
  assign o_mem_write   = vld_q && dec_q.mem_write;
  assign o_illegal     = vld_q && dec_q.illegal;
  assign o_stall_count = stall_q;

endmodule

// File: tb/tb_id_stage_decoder.sv
// Directed bench for id_stage_decoder: decode vector table plus handshake/hazard/flush/reset sequences.
module tb_id_stage_decoder;

  logic        i_clk = 1'b0;
  logic        i_reset, i_valid, i_flush, i_ready;
  logic [31:0] i_instruction, i_pc;

  logic        o_ready, o_valid, o_reg_write, o_mem_read, o_mem_write, o_illegal;
  logic [31:0] o_pc, o_imm;
  logic [5:0]  o_opcode, o_funct;
  logic [4:0]  o_rs, o_rt, o_rd, o_shamt, o_dest;
  logic [25:0] o_jtarget;
  logic [15:0] o_stall_count;

  logic        w_ready, w_valid, w_reg_write, w_mem_read, w_mem_write, w_illegal;
  logic [31:0] w_pc;
  logic [63:0] w_imm;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_dest;
  logic [25:0] w_jtarget;
  logic [15:0] w_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  id_stage_decoder #(.DATA_W(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_pc(o_pc), .o_opcode(o_opcode), .o_funct(o_funct), .o_rs(o_rs),
    .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt), .o_dest(o_dest), .o_imm(o_imm),
    .o_jtarget(o_jtarget), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_illegal(o_illegal), .o_stall_count(o_stall_count)
  );

  id_stage_decoder #(.DATA_W(64)) dut64 (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(w_ready),
    .i_instruction(i_instruction), .i_pc(i_pc), .i_flush(i_flush), .o_valid(w_valid),
    .i_ready(i_ready), .o_pc(w_pc), .o_opcode(w_opcode), .o_funct(w_funct), .o_rs(w_rs),
    .o_rt(w_rt), .o_rd(w_rd), .o_shamt(w_shamt), .o_dest(w_dest), .o_imm(w_imm),
    .o_jtarget(w_jtarget), .o_reg_write(w_reg_write), .o_mem_read(w_mem_read),
    .o_mem_write(w_mem_write), .o_illegal(w_illegal), .o_stall_count(w_stall_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  dest;
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [3:0]  flags; // {reg_write, mem_read, mem_write, illegal}
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'h2008FFFF, 5'd8,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'b1000}; // ADDI
    vecs[1]  = '{32'h3408FFFF, 5'd8,  32'h0000FFFF, 64'h000000000000FFFF, 4'b1000}; // ORI
    vecs[2]  = '{32'h3C011234, 5'd1,  32'h12340000, 64'h0000000012340000, 4'b1000}; // LUI +
    vecs[3]  = '{32'h3C018000, 5'd1,  32'h80000000, 64'hFFFFFFFF80000000, 4'b1000}; // LUI -
    vecs[4]  = '{32'h01095020, 5'd10, 32'h00005020, 64'h0000000000005020, 4'b1000}; // ADD
    vecs[5]  = '{32'h03E00008, 5'd0,  32'h00000008, 64'h0000000000000008, 4'b0000}; // JR
    vecs[6]  = '{32'h0C000010, 5'd31, 32'h00000010, 64'h0000000000000010, 4'b1000}; // JAL
    vecs[7]  = '{32'h8C090000, 5'd9,  32'h00000000, 64'h0000000000000000, 4'b1100}; // LW
    vecs[8]  = '{32'hAC090004, 5'd9,  32'h00000004, 64'h0000000000000004, 4'b0010}; // SW
    vecs[9]  = '{32'h11090003, 5'd9,  32'h00000003, 64'h0000000000000003, 4'b0000}; // BEQ
    vecs[10] = '{32'h20000005, 5'd0,  32'h00000005, 64'h0000000000000005, 4'b0000}; // ADDI $0
    vecs[11] = '{32'hFC08FFFF, 5'd8,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 4'b0001}; // op 0x3F

    i_reset = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_instruction = '0; i_pc = '0;
    #12;
    chk("rst_valid", o_valid, 0);
    chk("rst_stall", o_stall_count, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_regwr", o_reg_write, 0);
    i_reset = 1'b0;
    tick();
    chk("post_rst_ready", o_ready, 1);

    // Decode table: one instruction, then an idle cycle so none of them interact.
    for (int i = 0; i < 12; i++) begin
      i_valid = 1'b1; i_instruction = vecs[i].instr; i_pc = 32'h1000 + 32'(i * 4);
      tick();
      i_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), o_valid, 1);
      chk($sformatf("v%0d_dest", i), o_dest, vecs[i].dest);
      chk($sformatf("v%0d_imm", i), o_imm, vecs[i].imm32);
      chk($sformatf("v%0d_imm64", i), w_imm, vecs[i].imm64);
      chk($sformatf("v%0d_flags", i), {o_reg_write, o_mem_read, o_mem_write, o_illegal}, vecs[i].flags);
      chk($sformatf("v%0d_pc", i), o_pc, 32'h1000 + 32'(i * 4));
      tick();
      chk($sformatf("v%0d_drain", i), o_valid, 0);
      chk($sformatf("v%0d_flags_idle", i), {o_reg_write, o_mem_read, o_mem_write, o_illegal}, 0);
    end

    // Load-use: LW $9 then ADD using $9 -> one bubble, then ADD.
    i_valid = 1'b1; i_instruction = 32'h8C090000;
    tick();
    chk("lu_lw_valid", o_valid, 1);
    i_instruction = 32'h01095020;
    #1;
    chk("lu_ready_low", o_ready, 0);
    tick();
    chk("lu_bubble", o_valid, 0);
    chk("lu_count", o_stall_count, 1);
    chk("lu_ready_back", o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("lu_add_valid", o_valid, 1);
    chk("lu_add_dest", o_dest, 10);
    chk("lu_add_funct", o_funct, 6'h20);
    tick();
    chk("lu_count_hold", o_stall_count, 1);

    // Backpressure: hold ADDI for 3 cycles while ORI waits, then release.
    i_ready = 1'b0; i_valid = 1'b1; i_instruction = 32'h2008FFFF;
    tick();
    i_instruction = 32'h3408FFFF;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d_ready", c), o_ready, 0);
      chk($sformatf("bp%0d_valid", c), o_valid, 1);
      chk($sformatf("bp%0d_imm", c), o_imm, 32'hFFFFFFFF);
      chk($sformatf("bp%0d_opcode", c), o_opcode, 6'h08);
      tick();
    end
    i_ready = 1'b1;
    #1;
    chk("bp_rel_ready", o_ready, 1);
    tick();
    i_valid = 1'b0;
    chk("bp_ori_valid", o_valid, 1);
    chk("bp_ori_imm", o_imm, 32'h0000FFFF);
    tick();
    chk("bp_single", o_valid, 0);

    // Flush with a held bundle and a valid incoming instruction.
    i_ready = 1'b0; i_valid = 1'b1; i_instruction = 32'h2008FFFF;
    tick();
    chk("fl_held", o_valid, 1);
    i_instruction = 32'h3C011234; i_flush = 1'b1;
    #1;
    chk("fl_ready", o_ready, 1);
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    chk("fl_valid", o_valid, 0);
    chk("fl_regwr", o_reg_write, 0);
    tick();
    chk("fl_no_ghost", o_valid, 0);

    // Reset mid-stall: LW held with a dependent ADD waiting, then reset.
    i_valid = 1'b1; i_instruction = 32'h8C090000;
    tick();
    i_ready = 1'b0; i_instruction = 32'h01095020;
    tick();
    chk("rs_hold_count", o_stall_count, 1);
    i_reset = 1'b1;
    #1;
    chk("rs_valid", o_valid, 0);
    chk("rs_count", o_stall_count, 0);
    chk("rs_memrd", o_mem_read, 0);
    tick();
    i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    tick();
    chk("rs_after_valid", o_valid, 0);
    chk("rs_after_count", o_stall_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage_decoder.md
ID_STAGE_DECODER -- requirements
Module: id_stage_decoder

Interface
REQ-001 Parameter DATA_W, default 32, immediate/data width; legal values 32, 64.
REQ-002 Parameter ADDR_W, default 32, PC width.
REQ-003 Parameter LOAD_USE_EN, default 1, enables load-use bubble insertion.
REQ-004 i_clk  in  1  clock, rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_valid  in  1  upstream (IF) instruction valid.
REQ-007 o_ready  out  1  stage accepts the instruction this cycle.
REQ-008 i_instruction  in  32  fetched MIPS instruction.
REQ-009 i_pc  in  ADDR_W  PC of i_instruction.
REQ-010 i_flush  in  1  squash held and incoming instructions (branch/jump redirect).
REQ-011 o_valid  out  1  decoded bundle valid to EX.
REQ-012 i_ready  in  1  EX accepts the bundle.
REQ-013 o_pc  out  ADDR_W  registered PC.
REQ-014 o_opcode, o_funct  out  6 each  instruction[31:26], [5:0].
REQ-015 o_rs, o_rt, o_rd, o_shamt  out  5 each  [25:21], [20:16], [15:11], [10:6].
REQ-016 o_dest  out  5  write register: rd for R-type, rt for I-type, 31 for JAL.
REQ-017 o_imm  out  DATA_W  extended immediate.
REQ-018 o_jtarget  out  26  instruction[25:0].
REQ-019 o_reg_write, o_mem_read, o_mem_write, o_illegal  out  1 each  control flags.
REQ-020 o_stall_count  out  16  saturating count of load-use bubbles.

Function
REQ-021 Input transfer occurs when i_valid && o_ready; output transfer occurs when o_valid && i_ready.
REQ-022 o_ready SHALL equal (!o_valid || i_ready) && !hazard; it has no combinational dependency on i_valid except through hazard.
REQ-023 On input transfer, all decoded fields SHALL be registered, giving a latency of one cycle (o_valid high on the next edge).
REQ-024 When o_valid && !i_ready, all outputs SHALL hold stable.
REQ-025 When an output transfer occurs without an input transfer, o_valid SHALL fall on the next edge.
REQ-026 hazard SHALL be LOAD_USE_EN && o_valid && o_mem_read && o_dest!=0 && i_valid && (rs==o_dest || (rt==o_dest && the incoming opcode reads rt: R-type, SW, BEQ, BNE)).
REQ-027 On hazard && i_ready, a bubble SHALL be issued (o_valid=0 next cycle) and o_stall_count SHALL increment, saturating at 0xFFFF; the stalled instruction is accepted the following cycle.
REQ-028 i_flush SHALL have priority over everything: o_valid=0 next edge, and an input presented in the same cycle is discarded; o_ready is high during flush.
REQ-029 Immediate: sign-extend instruction[15:0] to DATA_W; zero-extend for ANDI 0x0C, ORI 0x0D, XORI 0x0E; LUI 0x0F gives {imm,16'h0} sign-extended to DATA_W.
REQ-030 Legal opcodes: 0x00 (R), 0x02 J, 0x03 JAL, 0x04 BEQ, 0x05 BNE, 0x08-0x0F, 0x23 LW, 0x2B SW; any other opcode sets o_illegal=1 and clears all other control flags.
REQ-031 o_reg_write=1 for R-type except funct 0x08 (JR), for 0x08-0x0F, LW and JAL; it is forced to 0 whenever o_dest==0.
REQ-032 o_mem_read=1 only for LW; o_mem_write=1 only for SW.
REQ-033 Field outputs SHALL be don't-care while o_valid=0, but control flags SHALL be 0 while o_valid=0.

Reset
REQ-034 While i_reset is high, all outputs SHALL be 0, including o_valid and o_stall_count; o_ready is high after reset deasserts.
REQ-035 Reset mid-stall or mid-hold SHALL discard the held bundle; no bubble is counted.

Structure
REQ-036 Opcode/funct constants and the DATA_W legality check SHALL live in the shared package mips_pkg.
REQ-037 Field extraction, immediate extension and control generation SHALL be the combinational sub-module instr_field_decode; id_stage_decoder holds the handshake, hazard and registers.

Verification
REQ-038 Reset, then ADDI 0x2008FFFF with i_ready=1 -> next cycle o_valid=1, o_dest=8, o_imm=0xFFFFFFFF, o_reg_write=1.
REQ-039 ORI 0x3408FFFF with DATA_W=64 -> o_imm=0x000000000000FFFF.
REQ-040 LW 0x8C090000 then ADD 0x01095020 back-to-back -> one bubble, o_ready=0 for one cycle, o_stall_count=1, ADD is issued after.
REQ-041 i_ready held 0 for 3 cycles with a valid bundle -> outputs stable, o_ready=0, no loss; release -> single transfer.
REQ-042 i_flush with i_valid=1 and a held bundle -> o_valid=0 next cycle, incoming instruction never appears.
REQ-043 Opcode 0x3F -> o_illegal=1, o_reg_write=o_mem_read=o_mem_write=0.
